// File: rtl/vec_mem_reader.sv
// Memory-to-register deserializer: issues 1 (scalar) or I (vector) reads from a
// one-cycle-latency memory and assembles the returned items into an output register.
module vec_mem_reader #(
    parameter int I = 20,
    parameter int L = 8,
    parameter int A = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_op_type,
    input  logic [A-1:0]        i_base_address,
    input  logic [L-1:0]        i_read_data,
    output logic                o_read_en,
    output logic [A-1:0]        o_read_address,
    output logic [L-1:0]        o_scalar_data,
    output logic [I-1:0][L-1:0] o_vector_data,
    output logic                o_busy,
    output logic                o_finished
);

    localparam int CW = $clog2(I + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_op_type;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_issue_idx;
    logic [CW-1:0]       r_cap_idx;
    logic                r_capture;
    logic [A-1:0]        r_read_address;
    logic [I-1:0][L-1:0] r_assembly;
    logic [I-1:0][L-1:0] w_assembly_next;
    logic [L-1:0]        r_scalar_data;
    logic [I-1:0][L-1:0] r_vector_data;
    logic                w_last_issue;

    assign w_last_issue = (r_issue_idx == r_count - CW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = ISSUE;
            ISSUE:   if (w_last_issue) w_state_next = DRAIN;
            DRAIN:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Read data lands one cycle after its ISSUE cycle; the slot write is formed
    // combinationally so DRAIN can publish the final item in the same edge.
    generate
        for (genvar gi = 0; gi < I; gi++) begin : g_slot
            assign w_assembly_next[gi] = (r_capture && (r_cap_idx == CW'(gi)))
                                         ? i_read_data : r_assembly[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_type      <= 1'b0;
            r_count        <= '0;
            r_issue_idx    <= '0;
            r_cap_idx      <= '0;
            r_capture      <= 1'b0;
            r_read_address <= '0;
            r_assembly     <= '0;
            r_scalar_data  <= '0;
            r_vector_data  <= '0;
        end else begin
            r_capture  <= (r_state == ISSUE);
            r_assembly <= w_assembly_next;
            if (r_capture) begin
                r_cap_idx <= r_cap_idx + CW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op_type      <= i_op_type;
                        r_count        <= i_op_type ? CW'(I) : CW'(1);
                        r_issue_idx    <= '0;
                        r_cap_idx      <= '0;
                        r_read_address <= i_base_address;
                    end
                end
                ISSUE: begin
                    // The address naturally wraps modulo 2^A; it holds on the last issue.
                    if (!w_last_issue) begin
                        r_issue_idx    <= r_issue_idx + CW'(1);
                        r_read_address <= r_read_address + A'(1);
                    end
                end
                DRAIN: begin
                    if (r_op_type) begin
                        r_vector_data <= w_assembly_next;
                    end else begin
                        r_scalar_data <= w_assembly_next[0];
                    end
                end
                DONE: begin
                    r_read_address <= '0;
                end
                default: begin
                    r_read_address <= '0;
                end
            endcase
        end
    end

    assign o_read_en      = (r_state == ISSUE);
    assign o_read_address = r_read_address;
    assign o_scalar_data  = r_scalar_data;
    assign o_vector_data  = r_vector_data;
    assign o_busy         = (r_state != IDLE);
    assign o_finished     = (r_state == DONE);

endmodule

// File: doc/vec_mem_reader.md
VEC_MEM_READER -- requirements
Module: vec_mem_reader

Interface
REQ-001 Parameter I, default 20, number of items per vector.
REQ-002 Parameter L, default 8, item width in bits and memory data width.
REQ-003 Parameter A, default 6, memory address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 op_type  input  1  0 = scalar load (1 item), 1 = vector load (I items).
REQ-008 base_address  input  A  address of item 0; sampled with start.
REQ-009 read_data  input  L  memory read port; valid one cycle after read_address/read_en.
REQ-010 read_en  output  1  memory read strobe.
REQ-011 read_address  output  A  memory read address.
REQ-012 scalar_data  output  L  result of last completed scalar load.
REQ-013 vector_data  output  I x L  result of last completed vector load; item k at index k.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 finished  output  1  one-cycle completion pulse.

Function
REQ-016 The block SHALL be the memory-to-register deserializer, the inverse of the stage's serializing write path: one L-bit item per cycle in, I-item vector out.
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE -> ISSUE on start=1; base_address and op_type are latched, item count n = op_type ? I : 1, issue index and capture index cleared.
REQ-019 In ISSUE, read_en=1 and read_address=latched base + issue index, modulo 2^A (wrap 2^A-1 -> 0); index increments every cycle.
REQ-020 ISSUE -> DRAIN in the cycle the issue index equals n-1.
REQ-021 Each cycle after an ISSUE cycle, read_data SHALL be captured into assembly register slot = capture index, and the capture index incremented.
REQ-022 In DRAIN, read_en=0, read_address holds its last value, and the final item is captured; DRAIN -> DONE unconditionally.
REQ-023 In DONE, finished=1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-024 On entry to DONE, a vector load SHALL copy the assembly register to vector_data; a scalar load SHALL copy slot 0 to scalar_data; the non-selected output is unchanged.
REQ-025 vector_data and scalar_data SHALL hold stable between completions, never showing partial data.
REQ-026 Latency, with start sampled at edge 0: first read_en in cycle 1, finished high in cycle n+2 (vector 22, scalar 3 at default I).
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 start in the DONE cycle SHALL be ignored; a new start is accepted from the IDLE cycle that follows.
REQ-029 read_en=0 and finished=0 in IDLE; read_address SHALL be 0 in IDLE.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force IDLE, clear all indices, the assembly register, vector_data, scalar_data, read_address, and deassert read_en, busy and finished.
REQ-031 Reset asserted mid-operation SHALL abort the load with no finished pulse and no output update; after release the block waits in IDLE for a new start.

Verification
REQ-032 Memory model mem[a]=a+8'h10. Vector load at base 6'd0 -> read_address 0..19 in cycles 1..20, finished in cycle 22, vector_data[k]=k+8'h10.
REQ-033 Scalar load at base 6'd37 -> single read_en cycle at address 37, finished in cycle 3, scalar_data=8'h35, vector_data unchanged.
REQ-034 Vector load at base 6'd50 -> addresses 50..63 then 0..5, vector_data[13]=8'h4F and vector_data[14]=8'h10.
REQ-035 Second start at cycle 5 of a vector load -> ignored, exactly one finished pulse; start in the following IDLE cycle is accepted.
REQ-036 rst=0 at cycle 10 of a vector load -> read_en low at once, outputs zero, no finished pulse; a subsequent scalar load completes normally.
